// File: rtl/dma2mem_stream_monitor.sv
// Per-lane DMA-to-memc monitor: per-stream event counters, outstanding-read tracking,
// write checksums and first-violation capture, read back through a stream-select port.
module dma2mem_stream_monitor #(
  parameter int NUM_STREAMS     = 2,
  parameter int ADDR_W          = 24,
  parameter int DATA_W          = 32,
  parameter int CNT_W           = 16,
  parameter int MAX_OUTSTANDING = 8,
  localparam int SEL_W = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1,
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1) + 1
) (
  input  logic                          clk,
  input  logic                          reset_poweron_n,
  input  logic [NUM_STREAMS-1:0]        dma__memc__write_valid,
  input  logic [NUM_STREAMS*ADDR_W-1:0] dma__memc__write_address,
  input  logic [NUM_STREAMS*DATA_W-1:0] dma__memc__write_data,
  input  logic [NUM_STREAMS-1:0]        memc__dma__write_ready,
  input  logic [NUM_STREAMS-1:0]        dma__memc__read_valid,
  input  logic [NUM_STREAMS*ADDR_W-1:0] dma__memc__read_address,
  input  logic [NUM_STREAMS-1:0]        memc__dma__read_ready,
  input  logic [NUM_STREAMS-1:0]        dma__memc__read_pause,
  input  logic [NUM_STREAMS-1:0]        memc__dma__read_data_valid,
  input  logic                          cfg__enable,
  input  logic                          cfg__clear,
  input  logic [ADDR_W-1:0]             cfg__addr_lo,
  input  logic [ADDR_W-1:0]             cfg__addr_hi,
  input  logic [SEL_W-1:0]              cfg__stream_sel,
  output logic [CNT_W-1:0]              mon__write_count,
  output logic [CNT_W-1:0]              mon__read_req_count,
  output logic [CNT_W-1:0]              mon__read_data_count,
  output logic [OUT_W-1:0]              mon__outstanding,
  output logic [DATA_W-1:0]             mon__write_checksum,
  output logic [1:0]                    mon__state,
  output logic                          mon__error,
  output logic [2:0]                    mon__error_code,
  output logic [SEL_W-1:0]              mon__error_stream,
  output logic [ADDR_W-1:0]             mon__error_addr
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_ERR  = 2'b10
  } state_t;

  typedef enum logic [2:0] {
    CODE_NONE      = 3'd0,
    CODE_UNDERFLOW = 3'd1,
    CODE_OVERFLOW  = 3'd2,
    CODE_PAUSE     = 3'd3,
    CODE_RANGE     = 3'd4
  } code_t;

  localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUTSTANDING);

  state_t state_q, state_d;

  logic [CNT_W-1:0]  wr_cnt   [NUM_STREAMS];
  logic [CNT_W-1:0]  rreq_cnt [NUM_STREAMS];
  logic [CNT_W-1:0]  rdat_cnt [NUM_STREAMS];
  logic [OUT_W-1:0]  outst    [NUM_STREAMS];
  logic [DATA_W-1:0] csum     [NUM_STREAMS];
  logic [NUM_STREAMS-1:0] pause_prev;

  logic [ADDR_W-1:0] wr_addr [NUM_STREAMS];
  logic [ADDR_W-1:0] rd_addr [NUM_STREAMS];
  logic [DATA_W-1:0] wr_data [NUM_STREAMS];
  logic [NUM_STREAMS-1:0] w_acc, r_acc, d_evt;
  logic [NUM_STREAMS-1:0] under_v, over_v, pause_v, wr_oor_v, rd_oor_v;

  logic              viol_found;
  code_t             viol_code;
  logic [SEL_W-1:0]  viol_stream;
  logic [ADDR_W-1:0] viol_addr;
  logic              capture;
  logic              count_en;

  logic              err_flag;
  code_t             err_code;
  logic [SEL_W-1:0]  err_stream;
  logic [ADDR_W-1:0] err_addr;

  logic [CNT_W-1:0]  sel_wr, sel_rreq, sel_rdat;
  logic [OUT_W-1:0]  sel_outst;
  logic [DATA_W-1:0] sel_csum;

  always_comb begin
    w_acc = dma__memc__write_valid & memc__dma__write_ready;
    r_acc = dma__memc__read_valid & memc__dma__read_ready;
    d_evt = memc__dma__read_data_valid;
    for (int s = 0; s < NUM_STREAMS; s++) begin
      wr_addr[s] = dma__memc__write_address[s*ADDR_W +: ADDR_W];
      rd_addr[s] = dma__memc__read_address[s*ADDR_W +: ADDR_W];
      wr_data[s] = dma__memc__write_data[s*DATA_W +: DATA_W];
    end
  end

  // Raw per-stream violation conditions; pause_prev holds last cycle's pause level.
  always_comb begin
    under_v  = '0;
    over_v   = '0;
    pause_v  = '0;
    wr_oor_v = '0;
    rd_oor_v = '0;
    for (int s = 0; s < NUM_STREAMS; s++) begin
      under_v[s]  = d_evt[s] && (outst[s] == '0);
      over_v[s]   = r_acc[s] && !d_evt[s] && (outst[s] == OUT_MAX);
      pause_v[s]  = d_evt[s] && dma__memc__read_pause[s] && pause_prev[s];
      wr_oor_v[s] = w_acc[s] && ((wr_addr[s] < cfg__addr_lo) || (wr_addr[s] > cfg__addr_hi));
      rd_oor_v[s] = r_acc[s] && ((rd_addr[s] < cfg__addr_lo) || (rd_addr[s] > cfg__addr_hi));
    end
  end

  // Walk streams from highest to lowest so the lowest violating stream overrides.
  always_comb begin
    viol_found  = 1'b0;
    viol_code   = CODE_NONE;
    viol_stream = '0;
    viol_addr   = '0;
    for (int s = NUM_STREAMS - 1; s >= 0; s--) begin
      if (under_v[s]) begin
        viol_found = 1'b1; viol_code = CODE_UNDERFLOW; viol_stream = SEL_W'(s); viol_addr = '0;
      end else if (over_v[s]) begin
        viol_found = 1'b1; viol_code = CODE_OVERFLOW; viol_stream = SEL_W'(s); viol_addr = '0;
      end else if (pause_v[s]) begin
        viol_found = 1'b1; viol_code = CODE_PAUSE; viol_stream = SEL_W'(s); viol_addr = '0;
      end else if (wr_oor_v[s]) begin
        viol_found = 1'b1; viol_code = CODE_RANGE; viol_stream = SEL_W'(s); viol_addr = wr_addr[s];
      end else if (rd_oor_v[s]) begin
        viol_found = 1'b1; viol_code = CODE_RANGE; viol_stream = SEL_W'(s); viol_addr = rd_addr[s];
      end
    end
  end

  assign capture  = (state_q == ST_RUN) && !cfg__clear && viol_found;
  assign count_en = (state_q != ST_IDLE);

  always_ff @(posedge clk or negedge reset_poweron_n) begin
    if (!reset_poweron_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (cfg__clear) begin
      state_d = cfg__enable ? ST_RUN : ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (cfg__enable) state_d = ST_RUN;
        ST_RUN: begin
          if (viol_found)        state_d = ST_ERR;
          else if (!cfg__enable) state_d = ST_IDLE;
        end
        ST_ERR:  state_d = ST_ERR;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Per-stream counters keep running in ERR; clear drops any same-cycle events.
  always_ff @(posedge clk or negedge reset_poweron_n) begin
    if (!reset_poweron_n) begin
      pause_prev <= '0;
      for (int s = 0; s < NUM_STREAMS; s++) begin
        wr_cnt[s]   <= '0;
        rreq_cnt[s] <= '0;
        rdat_cnt[s] <= '0;
        outst[s]    <= '0;
        csum[s]     <= '0;
      end
    end else if (cfg__clear) begin
      pause_prev <= '0;
      for (int s = 0; s < NUM_STREAMS; s++) begin
        wr_cnt[s]   <= '0;
        rreq_cnt[s] <= '0;
        rdat_cnt[s] <= '0;
        outst[s]    <= '0;
        csum[s]     <= '0;
      end
    end else begin
      pause_prev <= dma__memc__read_pause;
      if (count_en) begin
        for (int s = 0; s < NUM_STREAMS; s++) begin
          if (w_acc[s] && (wr_cnt[s] != '1))   wr_cnt[s]   <= wr_cnt[s] + 1'b1;
          if (r_acc[s] && (rreq_cnt[s] != '1)) rreq_cnt[s] <= rreq_cnt[s] + 1'b1;
          if (d_evt[s] && (rdat_cnt[s] != '1)) rdat_cnt[s] <= rdat_cnt[s] + 1'b1;
          if (w_acc[s]) csum[s] <= csum[s] + wr_data[s];
          if (r_acc[s] && !d_evt[s] && (outst[s] != OUT_MAX)) begin
            outst[s] <= outst[s] + 1'b1;
          end else if (d_evt[s] && !r_acc[s] && (outst[s] != '0)) begin
            outst[s] <= outst[s] - 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_poweron_n) begin
    if (!reset_poweron_n) begin
      err_flag   <= 1'b0;
      err_code   <= CODE_NONE;
      err_stream <= '0;
      err_addr   <= '0;
    end else if (cfg__clear) begin
      err_flag   <= 1'b0;
      err_code   <= CODE_NONE;
      err_stream <= '0;
      err_addr   <= '0;
    end else if (capture) begin
      err_flag   <= 1'b1;
      err_code   <= viol_code;
      err_stream <= viol_stream;
      err_addr   <= viol_addr;
    end
  end

  always_comb begin
    sel_wr    = '0;
    sel_rreq  = '0;
    sel_rdat  = '0;
    sel_outst = '0;
    sel_csum  = '0;
    for (int s = 0; s < NUM_STREAMS; s++) begin
      if (cfg__stream_sel == SEL_W'(s)) begin
        sel_wr    = wr_cnt[s];
        sel_rreq  = rreq_cnt[s];
        sel_rdat  = rdat_cnt[s];
        sel_outst = outst[s];
        sel_csum  = csum[s];
      end
    end
  end

  // Output stage: every readout is one register behind the internal state.
  always_ff @(posedge clk or negedge reset_poweron_n) begin
    if (!reset_poweron_n) begin
      mon__write_count     <= '0;
      mon__read_req_count  <= '0;
      mon__read_data_count <= '0;
      mon__outstanding     <= '0;
      mon__write_checksum  <= '0;
      mon__state           <= ST_IDLE;
      mon__error           <= 1'b0;
      mon__error_code      <= CODE_NONE;
      mon__error_stream    <= '0;
      mon__error_addr      <= '0;
    end else begin
      mon__write_count     <= sel_wr;
      mon__read_req_count  <= sel_rreq;
      mon__read_data_count <= sel_rdat;
      mon__outstanding     <= sel_outst;
      mon__write_checksum  <= sel_csum;
      mon__state           <= state_q;
      mon__error           <= err_flag;
      mon__error_code      <= err_code;
      mon__error_stream    <= err_stream;
      mon__error_addr      <= err_addr;
    end
  end

endmodule

// File: tb/tb_dma2mem_stream_monitor.sv
// Directed bench for dma2mem_stream_monitor; a second instance with CNT_W=4 checks saturation.
module tb_dma2mem_stream_monitor;

  localparam int NS = 2;
  localparam int AW = 24;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NS-1:0] wv, wr, rv, rr, pz, dv;
  logic [NS*AW-1:0] wa, ra;
  logic [NS*DW-1:0] wd;
  logic          enable, clear;
  logic [AW-1:0] addr_lo, addr_hi;
  logic [0:0]    sel;

  logic [15:0] wc, rqc, rdc;
  logic [4:0]  outst;
  logic [31:0] csum;
  logic [1:0]  state;
  logic        err;
  logic [2:0]  code;
  logic [0:0]  estream;
  logic [23:0] eaddr;

  logic [3:0]  s_wc, s_rqc, s_rdc;
  logic [4:0]  s_outst;
  logic [31:0] s_csum;
  logic [1:0]  s_state;
  logic        s_err;
  logic [2:0]  s_code;
  logic [0:0]  s_estream;
  logic [23:0] s_eaddr;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  dma2mem_stream_monitor dut (
    .clk(clk), .reset_poweron_n(rst_n),
    .dma__memc__write_valid(wv), .dma__memc__write_address(wa), .dma__memc__write_data(wd),
    .memc__dma__write_ready(wr), .dma__memc__read_valid(rv), .dma__memc__read_address(ra),
    .memc__dma__read_ready(rr), .dma__memc__read_pause(pz), .memc__dma__read_data_valid(dv),
    .cfg__enable(enable), .cfg__clear(clear), .cfg__addr_lo(addr_lo), .cfg__addr_hi(addr_hi),
    .cfg__stream_sel(sel),
    .mon__write_count(wc), .mon__read_req_count(rqc), .mon__read_data_count(rdc),
    .mon__outstanding(outst), .mon__write_checksum(csum), .mon__state(state),
    .mon__error(err), .mon__error_code(code), .mon__error_stream(estream),
    .mon__error_addr(eaddr)
  );

  dma2mem_stream_monitor #(.CNT_W(4)) dut_sat (
    .clk(clk), .reset_poweron_n(rst_n),
    .dma__memc__write_valid(wv), .dma__memc__write_address(wa), .dma__memc__write_data(wd),
    .memc__dma__write_ready(wr), .dma__memc__read_valid(rv), .dma__memc__read_address(ra),
    .memc__dma__read_ready(rr), .dma__memc__read_pause(pz), .memc__dma__read_data_valid(dv),
    .cfg__enable(enable), .cfg__clear(clear), .cfg__addr_lo(addr_lo), .cfg__addr_hi(addr_hi),
    .cfg__stream_sel(sel),
    .mon__write_count(s_wc), .mon__read_req_count(s_rqc), .mon__read_data_count(s_rdc),
    .mon__outstanding(s_outst), .mon__write_checksum(s_csum), .mon__state(s_state),
    .mon__error(s_err), .mon__error_code(s_code), .mon__error_stream(s_estream),
    .mon__error_addr(s_eaddr)
  );

  task automatic applyStimulus(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    wv = '0; rv = '0; pz = '0; dv = '0;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; clear = 1'b0; sel = '0;
    addr_lo = 24'h000100; addr_hi = 24'h0001FF;
    wr = '1; rr = '1; wa = '0; ra = '0; wd = '0;
    idleInputs();
    applyStimulus(3);
    checkOutput("reset_state", 64'(state), 64'd0);
    checkOutput("reset_error", 64'(err), 64'd0);
    checkOutput("reset_wc", 64'(wc), 64'd0);
    checkOutput("reset_outst", 64'(outst), 64'd0);
    checkOutput("reset_csum", 64'(csum), 64'd0);
    rst_n = 1'b1;
    applyStimulus(1);

    // Enable with a write in the same cycle: that write must not be counted
    enable = 1'b1;
    wv[1] = 1'b1; wa[AW +: AW] = 24'h000100; wd[DW +: DW] = 32'd100;
    applyStimulus(1);
    for (int i = 1; i <= 5; i++) begin
      wa[AW +: AW] = 24'h000100 + 24'(i);
      wd[DW +: DW] = 32'(i);
      applyStimulus(1);
    end
    idleInputs(); sel = 1'b1;
    applyStimulus(1);
    checkOutput("run_state", 64'(state), 64'd1);
    checkOutput("s1_write_count", 64'(wc), 64'd5);
    checkOutput("s1_checksum", 64'(csum), 64'd15);
    sel = 1'b0;
    applyStimulus(1);
    checkOutput("s0_write_count", 64'(wc), 64'd0);
    checkOutput("s0_checksum", 64'(csum), 64'd0);
    checkOutput("s0_read_req", 64'(rqc), 64'd0);

    // Outstanding tracking on stream 0
    rv[0] = 1'b1; ra[0 +: AW] = 24'h000120;
    applyStimulus(3);
    idleInputs();
    applyStimulus(1);
    checkOutput("outst_after_3R", 64'(outst), 64'd3);
    checkOutput("rreq_after_3R", 64'(rqc), 64'd3);
    rv[0] = 1'b1; dv[0] = 1'b1;
    applyStimulus(1);
    idleInputs();
    applyStimulus(1);
    checkOutput("outst_R_and_D", 64'(outst), 64'd3);
    checkOutput("rreq_R_and_D", 64'(rqc), 64'd4);
    dv[0] = 1'b1;
    applyStimulus(3);
    idleInputs();
    applyStimulus(1);
    checkOutput("outst_drained", 64'(outst), 64'd0);
    checkOutput("rdata_count", 64'(rdc), 64'd4);

    // Single-cycle pause with D is legal; two consecutive pause cycles with D are not
    rv[0] = 1'b1;
    applyStimulus(1);
    idleInputs(); pz[0] = 1'b1; dv[0] = 1'b1;
    applyStimulus(1);
    idleInputs();
    applyStimulus(1);
    checkOutput("pause1_no_error", 64'(err), 64'd0);
    checkOutput("pause1_state", 64'(state), 64'd1);
    checkOutput("pause1_outst", 64'(outst), 64'd0);
    rv[0] = 1'b1;
    applyStimulus(1);
    idleInputs(); pz[0] = 1'b1;
    applyStimulus(1);
    pz[0] = 1'b1; dv[0] = 1'b1;
    applyStimulus(1);
    idleInputs();
    applyStimulus(1);
    checkOutput("pause_error", 64'(err), 64'd1);
    checkOutput("pause_state", 64'(state), 64'd2);
    checkOutput("pause_code", 64'(code), 64'd3);
    checkOutput("pause_stream", 64'(estream), 64'd0);
    checkOutput("pause_addr", 64'(eaddr), 64'd0);

    // Clear with a same-cycle write on stream 1
    clear = 1'b1; sel = 1'b1;
    wv[1] = 1'b1; wa[AW +: AW] = 24'h000110; wd[DW +: DW] = 32'd7;
    applyStimulus(1);
    clear = 1'b0; idleInputs();
    applyStimulus(1);
    checkOutput("clear_state", 64'(state), 64'd1);
    checkOutput("clear_wc", 64'(wc), 64'd0);
    checkOutput("clear_csum", 64'(csum), 64'd0);
    checkOutput("clear_error", 64'(err), 64'd0);
    checkOutput("clear_code", 64'(code), 64'd0);

    // Underflow, then a later range violation that must not overwrite it
    sel = 1'b0; dv[0] = 1'b1;
    applyStimulus(1);
    idleInputs();
    applyStimulus(1);
    checkOutput("under_state", 64'(state), 64'd2);
    checkOutput("under_code", 64'(code), 64'd1);
    checkOutput("under_stream", 64'(estream), 64'd0);
    checkOutput("under_addr", 64'(eaddr), 64'd0);
    checkOutput("under_rdc", 64'(rdc), 64'd1);
    checkOutput("under_outst", 64'(outst), 64'd0);
    wv[1] = 1'b1; wa[AW +: AW] = 24'h000300; wd[DW +: DW] = 32'd2; sel = 1'b1;
    applyStimulus(1);
    idleInputs();
    applyStimulus(1);
    checkOutput("frozen_code", 64'(code), 64'd1);
    checkOutput("frozen_stream", 64'(estream), 64'd0);
    checkOutput("frozen_addr", 64'(eaddr), 64'd0);
    checkOutput("err_still_counts", 64'(wc), 64'd1);

    // Overflow: nine reads against a ceiling of eight
    clear = 1'b1; sel = 1'b0;
    applyStimulus(1);
    clear = 1'b0; rv[0] = 1'b1; ra[0 +: AW] = 24'h000120;
    applyStimulus(9);
    idleInputs();
    applyStimulus(1);
    checkOutput("over_state", 64'(state), 64'd2);
    checkOutput("over_code", 64'(code), 64'd2);
    checkOutput("over_outst", 64'(outst), 64'd8);
    checkOutput("over_rreq", 64'(rqc), 64'd9);

    // Window edges are legal; then simultaneous out-of-range on both streams
    clear = 1'b1;
    applyStimulus(1);
    clear = 1'b0;
    wv[1] = 1'b1; wa[AW +: AW] = 24'h000100;
    rv[0] = 1'b1; ra[0 +: AW] = 24'h0001FF;
    applyStimulus(1);
    idleInputs();
    applyStimulus(1);
    checkOutput("edges_no_error", 64'(err), 64'd0);
    wv[1] = 1'b1; wa[AW +: AW] = 24'h000200;
    rv[0] = 1'b1; ra[0 +: AW] = 24'h0000FF;
    applyStimulus(1);
    idleInputs();
    applyStimulus(1);
    checkOutput("range_error", 64'(err), 64'd1);
    checkOutput("range_code", 64'(code), 64'd4);
    checkOutput("range_stream", 64'(estream), 64'd0);
    checkOutput("range_addr", 64'(eaddr), 64'h0000FF);

    // Saturation: 20 writes, CNT_W=4 instance pins at 15
    clear = 1'b1;
    applyStimulus(1);
    clear = 1'b0; sel = 1'b1;
    wv[1] = 1'b1; wa[AW +: AW] = 24'h000150; wd[DW +: DW] = 32'd1;
    applyStimulus(20);
    idleInputs();
    applyStimulus(1);
    checkOutput("wc_20", 64'(wc), 64'd20);
    checkOutput("sat_wc_15", 64'(s_wc), 64'd15);
    checkOutput("csum_20", 64'(csum), 64'd20);

    // Asynchronous reset between clock edges
    #3 rst_n = 1'b0;
    #1;
    checkOutput("areset_wc", 64'(wc), 64'd0);
    checkOutput("areset_sat_wc", 64'(s_wc), 64'd0);
    checkOutput("areset_csum", 64'(csum), 64'd0);
    checkOutput("areset_state", 64'(state), 64'd0);
    checkOutput("areset_error", 64'(err), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
